// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: NOP encoding, 2-bit
// branch counter encodings, the BTB entry layout and the counter update rule.
package if_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // 2-bit saturating direction counter encodings
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  // Tag is stored right-aligned in a 30-bit field so the struct does not
  // depend on the BTB depth; unused upper bits are always zero.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  // Saturating counter step: up on taken, down on not-taken, clamped at 00/11.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    case (ctr)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = WNT;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/if_stage_btb.sv
// Direct-mapped branch target buffer with 2-bit counters.
// Only built when IF_BTB_EN is defined; otherwise this file is empty.
// Lookup is combinational on the fetch PC and reads pre-update contents;
// the update port writes at the clock edge.
`ifdef IF_BTB_EN
module btb
  import if_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_pc,
  output logic        lookup_taken,
  output logic [31:0] lookup_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken
);

  localparam int IDX = $clog2(BTB_ENTRIES);

  btb_entry_t     entry_q [BTB_ENTRIES];
  btb_entry_t     entry_d [BTB_ENTRIES];
  logic [IDX-1:0] lk_idx_s;
  logic [IDX-1:0] up_idx_s;
  logic [29:0]    lk_tag_s;
  logic [29:0]    up_tag_s;
  btb_entry_t     lk_entry_s;
  btb_entry_t     up_entry_s;
  logic           up_match_s;

  // Tag is everything above the index bits, right-aligned.
  function automatic logic [29:0] tag_of(input logic [31:0] pc);
    return 30'(pc >> (IDX + 2));
  endfunction

  // Lookup: predict taken only on a valid, tag-matching, taken-leaning entry.
  always_comb begin
    lk_idx_s   = lookup_pc[IDX+1:2];
    lk_tag_s   = tag_of(lookup_pc);
    lk_entry_s = entry_q[lk_idx_s];
    if (lk_entry_s.valid && (lk_entry_s.tag == lk_tag_s) && lk_entry_s.ctr[1]) begin
      lookup_taken  = 1'b1;
      lookup_target = lk_entry_s.target;
    end else begin
      lookup_taken  = 1'b0;
      lookup_target = 32'h0000_0000;
    end
  end

  // Update: train a matching entry, allocate on a taken miss, else leave alone.
  always_comb begin
    entry_d    = entry_q;
    up_idx_s   = upd_pc[IDX+1:2];
    up_tag_s   = tag_of(upd_pc);
    up_entry_s = entry_q[up_idx_s];
    up_match_s = up_entry_s.valid && (up_entry_s.tag == up_tag_s);
    if (upd_en) begin
      if (up_match_s) begin
        entry_d[up_idx_s].ctr = ctr_update(up_entry_s.ctr, upd_taken);
        if (upd_taken) begin
          entry_d[up_idx_s].target = upd_target;
        end else begin
          entry_d[up_idx_s].target = up_entry_s.target;
        end
      end else if (upd_taken) begin
        entry_d[up_idx_s] = '{valid: 1'b1, tag: up_tag_s, target: upd_target, ctr: WT};
      end else begin
        entry_d[up_idx_s] = up_entry_s;
      end
    end else begin
      entry_d[up_idx_s] = up_entry_s;
    end
  end

  // Storage: reset clears valid and sets counters weakly not-taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        entry_q[i] <= '{valid: 1'b0, tag: 30'd0, target: 32'd0, ctr: WNT};
      end
    end else begin
      entry_q <= entry_d;
    end
  end

endmodule
`endif

// File: rtl/if_stage.sv
// Instruction-fetch stage and IF/ID pipeline register of the RV32I core.
// Optional branch prediction is enabled by defining IF_BTB_EN; without it
// fetch is purely sequential and hit/pred_target stay 0.
module if_stage
  import if_pkg::*;
#(
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] INST,
  output logic [31:0] PC_out,
  output logic        hit,
  output logic [31:0] pred_target
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        hit_q, hit_d;
  logic [31:0] pred_target_q, pred_target_d;
  logic        pred_taken_s;
  logic [31:0] btb_target_s;
  logic        unused_s;

`ifdef IF_BTB_EN
  btb #(
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .rst           (rst),
    .lookup_pc     (pc_q),
    .lookup_taken  (pred_taken_s),
    .lookup_target (btb_target_s),
    .upd_en        (upd_en),
    .upd_pc        (upd_pc),
    .upd_target    (upd_target),
    .upd_taken     (upd_taken)
  );
  assign unused_s = ^redirect_pc[1:0];
`else
  assign pred_taken_s = 1'b0;
  assign btb_target_s = 32'h0000_0000;
  assign unused_s     = ^{redirect_pc[1:0], upd_en, upd_pc, upd_target, upd_taken,
                          32'(BTB_ENTRIES)};
`endif

  assign imem_addr   = pc_q;
  assign INST        = inst_q;
  assign PC_out      = pc_out_q;
  assign hit         = hit_q;
  assign pred_target = pred_target_q;

  // Next-PC select: redirect beats stall beats prediction beats sequential.
  always_comb begin
    if (flush) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end else if (pred_taken_s) begin
      pc_d = btb_target_s;
    end else begin
      pc_d = pc_q + 32'd4;
    end
  end

  // IF/ID next state: flush squashes to a bubble even while stalled.
  always_comb begin
    if (flush) begin
      inst_d        = NOP_INST;
      pc_out_d      = 32'h0000_0000;
      hit_d         = 1'b0;
      pred_target_d = 32'h0000_0000;
    end else if (stall) begin
      inst_d        = inst_q;
      pc_out_d      = pc_out_q;
      hit_d         = hit_q;
      pred_target_d = pred_target_q;
    end else begin
      inst_d        = imem_rdata;
      pc_out_d      = pc_q;
      hit_d         = pred_taken_s;
      pred_target_d = pred_taken_s ? btb_target_s : 32'h0000_0000;
    end
  end

  // PC and IF/ID flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inst_q        <= NOP_INST;
      pc_out_q      <= 32'h0000_0000;
      hit_q         <= 1'b0;
      pred_target_q <= 32'h0000_0000;
    end else begin
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      pc_out_q      <= pc_out_d;
      hit_q         <= hit_d;
      pred_target_q <= pred_target_d;
    end
  end

endmodule
